// File: rtl/next_link_pkg.sv
// Shared constants and frame-geometry helpers for the NeXT serial link.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package next_link_pkg;

  localparam int PKT_W_DEF = 40;

  // Control-slot payloads: audio sample request and audio underrun.
  localparam logic [PKT_W_DEF-1:0] CTRL_REQ_DEF      = 40'h0700000000;
  localparam logic [PKT_W_DEF-1:0] CTRL_UNDERRUN_DEF = 40'h0f00000000;

  // Two slots of {start, payload} plus the two idle gaps.
  function automatic int frame_len(input int pkt_w, input int gap_a, input int gap_b);
    return 2 * (pkt_w + 1) + gap_a + gap_b;
  endfunction

  // Frame position of the data-slot start bit.
  function automatic int data_start(input int pkt_w, input int gap_a);
    return pkt_w + 1 + gap_a;
  endfunction

endpackage

// File: rtl/next_sender_fifo.sv
// Synchronous FIFO holding host packets waiting for a frame slot.
// Latency: a pushed entry is visible at head_o (and empty_o deasserts) the cycle after the push.
// Backpressure: full_o blocks pushes; a push while full is dropped even if a pop happens that cycle.
module next_sender_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               push_dat_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push;
  logic          do_pop;

  // Full is judged on the registered level only, so a same-cycle pop never frees a slot for a push.
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; level tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/next_packet_sender.sv
// Serial frame transmitter: control slot (request/underrun) + data slot (FIFO packets), MSB first with start bit.
// Latency: the bit for frame position k is on sout the cycle after the frame counter reads k.
// Backpressure: in_ready drops when the FIFO is full; pushes while full are dropped and counted in loss_count.
// Build option NEXT_SENDER_CTRL_DATA_EN: an idle control slot carries a FIFO packet instead of zeros.
module next_packet_sender
  import next_link_pkg::*;
#(
  parameter int               PKT_W         = PKT_W_DEF,
  parameter int               FIFO_DEPTH    = 4,
  parameter int               GAP_A         = 3,
  parameter int               GAP_B         = 1,
  parameter logic [PKT_W-1:0] CTRL_REQ      = CTRL_REQ_DEF,
  parameter logic [PKT_W-1:0] CTRL_UNDERRUN = CTRL_UNDERRUN_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PKT_W-1:0]                in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            audio_sample_request_mode,
  input  logic                            audio_sample_request_underrun,
  input  logic                            audio_sample_request_tick,
  output logic                            sout,
  output logic                            data_loss,
  output logic [7:0]                      loss_count,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int FRAME_LEN = frame_len(PKT_W, GAP_A, GAP_B);
  localparam int DS        = data_start(PKT_W, GAP_A);
  localparam int FCNT_W    = $clog2(FRAME_LEN);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN - 1);
  localparam logic [FCNT_W-1:0] DATA_LOAD = FCNT_W'(DS - 1);

  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [PKT_W:0]    shift_q, shift_d;
  logic              sout_q;
  logic              pend_und_q, pend_und_d;
  logic              pend_req_q, pend_req_d;
  logic              data_loss_q;
  logic [7:0]        loss_cnt_q, loss_cnt_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic [PKT_W-1:0]  fifo_head;
  logic              fifo_push;
  logic              fifo_pop;
  logic              reject;
  logic              eff_und;
  logic              eff_req;
  logic              ctrl_load;
  logic              data_load;

  next_sender_fifo #(
    .W     (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifo_push),
    .push_dat_i (in_data),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level)
  );

  assign in_ready   = ~fifo_full & ~rst;
  assign fifo_push  = in_valid & ~fifo_full;
  assign reject     = in_valid & fifo_full;
  assign sout       = sout_q;
  assign data_loss  = data_loss_q;
  assign loss_count = loss_cnt_q;

  // Frame sequencing, slot loads and request latching; a tick in a load cycle counts for that load.
  always_comb begin
    eff_und    = pend_und_q | (audio_sample_request_tick & audio_sample_request_underrun);
    eff_req    = pend_req_q | (audio_sample_request_tick & ~audio_sample_request_underrun
                               & audio_sample_request_mode);
    ctrl_load  = (fcnt_q == FCNT_LAST);
    data_load  = (fcnt_q == DATA_LOAD);
    fcnt_d     = ctrl_load ? '0 : fcnt_q + FCNT_W'(1);
    shift_d    = {shift_q[PKT_W-1:0], 1'b0};
    pend_und_d = eff_und;
    pend_req_d = eff_req;
    fifo_pop   = 1'b0;
    loss_cnt_d = loss_cnt_q;
    if (reject && (loss_cnt_q != 8'hff)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
    if (ctrl_load) begin
      if (eff_und) begin
        // Underrun wins; any pending request stays latched for the next frame.
        shift_d    = {1'b1, CTRL_UNDERRUN};
        pend_und_d = 1'b0;
      end else if (eff_req) begin
        shift_d    = {1'b1, CTRL_REQ};
        pend_req_d = 1'b0;
      end
`ifdef NEXT_SENDER_CTRL_DATA_EN
      else if (!fifo_empty) begin
        shift_d  = {1'b1, fifo_head};
        fifo_pop = 1'b1;
      end
`endif
      else begin
        shift_d = '0;
      end
    end else if (data_load) begin
      if (!fifo_empty) begin
        shift_d  = {1'b1, fifo_head};
        fifo_pop = 1'b1;
      end else begin
        shift_d = '0;
      end
    end
  end

  // State registers; reset parks the counter on the control-load position so a frame starts at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q      <= FCNT_LAST;
      shift_q     <= '0;
      sout_q      <= 1'b0;
      pend_und_q  <= 1'b0;
      pend_req_q  <= 1'b0;
      data_loss_q <= 1'b0;
      loss_cnt_q  <= '0;
    end else begin
      fcnt_q      <= fcnt_d;
      shift_q     <= shift_d;
      sout_q      <= shift_q[PKT_W];
      pend_und_q  <= pend_und_d;
      pend_req_q  <= pend_req_d;
      data_loss_q <= reject;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

endmodule
